// File: rtl/qspi_link_shifter.sv
// qspi_link_shifter: serialises one tx frame per handshake onto SCK/DQ
// (single/dual/quad lanes, MSB or LSB first), captures the same number of
// beats from DQ and returns one rx byte per frame. Also owns chip select.
module qspi_link_shifter #(
  parameter int DIV_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] io_ctrl_sck_div,
  input  logic             io_ctrl_sck_pol,
  input  logic             io_ctrl_sck_pha,
  output logic             io_link_tx_ready,
  input  logic             io_link_tx_valid,
  input  logic [7:0]       io_link_tx_bits,
  input  logic [7:0]       io_link_cnt,
  input  logic [1:0]       io_link_fmt_proto,
  input  logic             io_link_fmt_endian,
  input  logic             io_link_fmt_iodir,
  input  logic             io_link_cs_set,
  input  logic             io_link_cs_clear,
  input  logic             io_link_cs_hold,
  output logic             io_link_active,
  output logic             io_link_rx_valid,
  output logic [7:0]       io_link_rx_bits,
  output logic             io_sck,
  output logic             io_cs_n,
  output logic [3:0]       io_dq_o,
  output logic [3:0]       io_dq_oe,
  input  logic [3:0]       io_dq_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next, hcnt_reg, hcnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic [3:0]       n_reg, n_next;
  logic [4:0]       edge_reg, edge_next;
  logic             pol_reg, pol_next, pha_reg, pha_next;
  logic             endian_reg, endian_next, iodir_reg, iodir_next;
  logic             clear_reg, clear_next;
  logic [7:0]       tx_shift_reg, tx_shift_next, rx_shift_reg, rx_shift_next;
  logic [7:0]       rx_bits_reg, rx_bits_next;
  logic [3:0]       dq_o_reg, dq_o_next;
  logic             sck_reg, sck_next, cs_n_reg, cs_n_next;
  logic             rx_valid_reg, rx_valid_next;

  logic [7:0]       tx_rev, tx_load;
  logic [3:0]       n_in;
  logic [1:0]       mode_in;
  logic [4:0]       edge_idx;
  logic             lead_edge;
  logic [3:0]       oe_mask;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tx_rev
      assign tx_rev[gi] = io_link_tx_bits[7-gi];
    end
  endgenerate

  // Mode 0 = single (proto 3 folds onto single), 1 = dual, 2 = quad.
  assign mode_in = (io_link_fmt_proto == 2'd3) ? 2'd0 : io_link_fmt_proto;
  assign n_in    = (io_link_cnt > 8'd8) ? 4'd8 : io_link_cnt[3:0];
  assign tx_load = io_link_fmt_endian ? tx_rev : io_link_tx_bits;

  // Returns {dq lanes, shifted tx register} for one beat.
  function automatic logic [11:0] drive_beat(input logic [7:0] sh, input logic [1:0] mode);
    case (mode)
      2'd1:    drive_beat = {2'b00, sh[7:6], sh[5:0], 2'b00};
      2'd2:    drive_beat = {sh[7:4], sh[3:0], 4'b0000};
      default: drive_beat = {3'b000, sh[7], sh[6:0], 1'b0};
    endcase
  endfunction

  // Single mode listens on dq[1] (MISO); wider modes use the low lanes.
  function automatic logic [7:0] sample_beat(input logic [7:0] sh, input logic [1:0] mode,
                                             input logic [3:0] dq);
    case (mode)
      2'd1:    sample_beat = {sh[5:0], dq[1:0]};
      2'd2:    sample_beat = {sh[3:0], dq};
      default: sample_beat = {sh[6:0], dq[1]};
    endcase
  endfunction

  // Left-align the captured bits to bit 7, zero-fill below, undo LSB-first order.
  function automatic logic [7:0] format_rx(input logic [7:0] sh, input logic [3:0] n,
                                           input logic [1:0] mode, input logic endian);
    logic [5:0] nl;
    logic [7:0] al;
    nl = {2'b00, n} << mode;
    if (nl >= 6'd8) al = sh;
    else            al = sh << (4'd8 - nl[3:0]);
    format_rx = al;
    if (endian) begin
      for (int i = 0; i < 8; i++) format_rx[i] = al[7-i];
    end
  endfunction

  // Lanes enabled during the shift phase; single mode always drives MOSI.
  always_comb begin
    case (mode_reg)
      2'd1:    oe_mask = iodir_reg ? 4'b0011 : 4'b0000;
      2'd2:    oe_mask = iodir_reg ? 4'b1111 : 4'b0000;
      default: oe_mask = 4'b0001;
    endcase
  end

  // Next-state and datapath: latch on fire, step beats on each sck edge, report in DONE.
  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    hcnt_next     = hcnt_reg;
    mode_next     = mode_reg;
    n_next        = n_reg;
    edge_next     = edge_reg;
    pol_next      = pol_reg;
    pha_next      = pha_reg;
    endian_next   = endian_reg;
    iodir_next    = iodir_reg;
    clear_next    = clear_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_bits_next  = rx_bits_reg;
    dq_o_next     = dq_o_reg;
    sck_next      = sck_reg;
    cs_n_next     = cs_n_reg;
    rx_valid_next = 1'b0;
    edge_idx      = edge_reg + 5'd1;
    lead_edge     = edge_idx[0];
    case (state_reg)
      IDLE: begin
        sck_next = io_ctrl_sck_pol;
        if (io_link_tx_valid) begin
          div_next      = io_ctrl_sck_div;
          mode_next     = mode_in;
          n_next        = n_in;
          pol_next      = io_ctrl_sck_pol;
          pha_next      = io_ctrl_sck_pha;
          endian_next   = io_link_fmt_endian;
          iodir_next    = io_link_fmt_iodir;
          clear_next    = io_link_cs_clear & ~io_link_cs_hold;
          tx_shift_next = tx_load;
          rx_shift_next = 8'h00;
          hcnt_next     = '0;
          edge_next     = 5'd0;
          if (io_link_cs_set) cs_n_next = 1'b0;
          if (n_in == 4'd0) begin
            state_next    = DONE;
            rx_valid_next = 1'b1;
            rx_bits_next  = 8'h00;
            if (io_link_cs_clear & ~io_link_cs_hold) cs_n_next = 1'b1;
          end else begin
            state_next = SHIFT;
            if (!io_ctrl_sck_pha) {dq_o_next, tx_shift_next} = drive_beat(tx_load, mode_in);
          end
        end
      end
      SHIFT: begin
        if (hcnt_reg == div_reg) begin
          hcnt_next = '0;
          sck_next  = ~sck_reg;
          edge_next = edge_idx;
          if (lead_edge ^ pha_reg)
            rx_shift_next = sample_beat(rx_shift_reg, mode_reg, io_dq_i);
          if (pha_reg ? lead_edge : (!lead_edge && (edge_idx != {n_reg, 1'b0})))
            {dq_o_next, tx_shift_next} = drive_beat(tx_shift_reg, mode_reg);
          if (edge_idx == {n_reg, 1'b0}) begin
            state_next    = DONE;
            rx_valid_next = 1'b1;
            rx_bits_next  = format_rx(rx_shift_next, n_reg, mode_reg, endian_reg);
            if (clear_reg) cs_n_next = 1'b1;
          end
        end else begin
          hcnt_next = hcnt_reg + DIV_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      hcnt_reg     <= '0;
      mode_reg     <= 2'd0;
      n_reg        <= 4'd0;
      edge_reg     <= 5'd0;
      pol_reg      <= 1'b0;
      pha_reg      <= 1'b0;
      endian_reg   <= 1'b0;
      iodir_reg    <= 1'b0;
      clear_reg    <= 1'b0;
      tx_shift_reg <= 8'h00;
      rx_shift_reg <= 8'h00;
      rx_bits_reg  <= 8'h00;
      dq_o_reg     <= 4'h0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 1'b1;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      hcnt_reg     <= hcnt_next;
      mode_reg     <= mode_next;
      n_reg        <= n_next;
      edge_reg     <= edge_next;
      pol_reg      <= pol_next;
      pha_reg      <= pha_next;
      endian_reg   <= endian_next;
      iodir_reg    <= iodir_next;
      clear_reg    <= clear_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_bits_reg  <= rx_bits_next;
      dq_o_reg     <= dq_o_next;
      sck_reg      <= sck_next;
      cs_n_reg     <= cs_n_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  assign io_link_tx_ready = (state_reg == IDLE);
  assign io_link_active   = (state_reg != IDLE);
  assign io_link_rx_valid = rx_valid_reg;
  assign io_link_rx_bits  = rx_bits_reg;
  assign io_sck           = sck_reg;
  assign io_cs_n          = cs_n_reg;
  assign io_dq_o          = dq_o_reg;
  assign io_dq_oe         = (state_reg == SHIFT) ? oe_mask : 4'b0000;

endmodule
